ram_cmd_master: RTL and testbench
=================================

// Module: ram_cmd_master
// PURPOSE
//  Initiator for the dual-port RAM 10-bit command interface (rx_valid/din in, dout/tx_valid out).
//  Converts single host write/read requests into command sequences:
//    00+addr = set write ptr, 01+data = write, 10+addr = set read ptr, 11 = read.
//  Captures the RAM read data and returns it to the host. Sits between the host/control logic and the RAM.
// PARAMETERS
//  ADDR_SIZE  8  width of address and data fields; din = ADDR_SIZE+2 bits
//  TIMEOUT    8  cycles R_WAIT waits for ram_tx_valid before flagging an error (>=1)
//  SKIP_WADDR 1  1: omit the 00 phase when cmd_addr equals the cached last write address
// PORTS
//  clk           in   1            clock, rising edge
//  rst_n         in   1            reset, asynchronous, active-low
//  cmd_valid     in   1            host request valid
//  cmd_ready     out  1            master can accept a request (high only in IDLE)
//  cmd_rw        in   1            0 = write, 1 = read
//  cmd_addr      in   ADDR_SIZE    RAM address
//  cmd_wdata     in   ADDR_SIZE    write data (ignored for reads)
//  rsp_valid     out  1            one-cycle pulse: read result available
//  rsp_data      out  ADDR_SIZE    read data; 0 on error
//  rsp_err       out  1            qualifies rsp_valid: read timed out
//  ram_rx_valid  out  1            command word valid to RAM
//  ram_din       out  ADDR_SIZE+2  command word {op[1:0], payload}
//  ram_dout      in   ADDR_SIZE    RAM read data
//  ram_tx_valid  in   1            RAM read data valid
//  busy          out  1            high whenever state != IDLE
// BEHAVIOUR
//  - Reset values: state=IDLE, cmd_ready=1, busy=0, rsp_valid=0, rsp_data=0, rsp_err=0,
//    ram_rx_valid=0, ram_din=0, waddr cache invalid, timeout counter=0. All outputs registered.
//  - Reset mid-sequence aborts immediately: no response is produced; the cache is invalidated.
//  - Accept: a request is taken on the edge where cmd_valid && cmd_ready. Fields are latched then;
//    cmd_* are don't-care afterwards.
//  - Idle drive: ram_rx_valid=0, ram_din=0 in every cycle not listed below.
//    - The RAM decodes op 11 without checking rx_valid, so ram_din[9:8] must never be 11 outside R_CMD.
//  - FSM: IDLE, W_ADDR, W_DATA, R_ADDR, R_CMD, R_WAIT, RESP.
//  - Write, request accepted at edge T:
//    - Cycle T+1 (W_ADDR): rx_valid=1, din={00,addr}.
//    - Cycle T+2 (W_DATA): rx_valid=1, din={01,wdata}.
//    - Cycle T+3: IDLE, cmd_ready=1.
//    - If SKIP_WADDR && cache valid && addr==cached: go directly to W_DATA at T+1; IDLE at T+2.
//    - The cache is loaded with addr in W_ADDR. No response is generated for writes.
//  - Read, request accepted at edge T:
//    - Cycle T+1 (R_ADDR): rx_valid=1, din={10,addr}.
//    - Cycle T+2 (R_CMD): rx_valid=1, din={11,0}.
//    - Cycle T+3 (R_WAIT): din=0. The RAM asserts tx_valid in this cycle.
//    - When ram_tx_valid=1 in R_WAIT: latch ram_dout and go to RESP.
//    - RESP cycle: rsp_valid=1, rsp_err=0, rsp_data=latched value. Nominal RESP is cycle T+4.
//    - The next cycle is IDLE.
//  - Timeout: the counter clears on entry to R_WAIT and increments each R_WAIT cycle without tx_valid.
//    - When the count reaches TIMEOUT: go to RESP with rsp_err=1, rsp_data=0.
//    - Counter width is clog2(TIMEOUT+1); the counter does not wrap.
//  - ram_tx_valid outside R_WAIT is ignored.
//  - rsp_valid has no backpressure. rsp_data/rsp_err hold their values until the next RESP.
//  - Back-to-back: with cmd_valid held high, the next request is accepted on the edge that leaves IDLE.
//    - Minimum spacing: 3 cycles for a write, 2 for a cached write, 5 for a read.
//  - Reads never touch the write-address cache. Writes never modify the RAM read pointer.
// TESTING
//  1. Reset, write addr=0x3C data=0xA5: din 0x03C then 0x1A5, one cycle each, rx_valid=1; cmd_ready low 2 cycles.
//  2. Repeat write to 0x3C with data 0x5A, SKIP_WADDR=1: only 0x15A issued; write to 0x3D: 0x03D, 0x15D.
//  3. Read 0x3C after test 2 (RAM model attached): din 0x23C, 0x300, then 0x000.
//     Expect rsp_valid one cycle with rsp_data=0x5A, rsp_err=0, exactly 4 cycles after accept.
//  4. Read with RAM tx_valid tied 0, TIMEOUT=8: rsp_valid with rsp_err=1, rsp_data=0 after 8 R_WAIT cycles;
//     then cmd_ready=1.
//  5. Assert rst_n low during W_DATA: outputs at reset values at once; next write to the same address
//     re-issues the 00 phase.
//  6. Continuous random write/read stream vs. scoreboard: ram_din[9:8]==11 only in R_CMD;
//     every read returns the last written data.

Source files
------------

// File: rtl/ram_cmd_master.sv
// Host-to-RAM command sequencer: turns one write/read request into 10-bit RAM command words and returns read data.
// Latency: write 2 cycles (1 on a cached address), read response nominally 4 cycles after accept, TIMEOUT bounds the wait.
// Backpressure: cmd_ready is high only in IDLE; rsp_valid is a one-cycle pulse with no backpressure.
module ram_cmd_master #(
    parameter int ADDR_SIZE  = 8,
    parameter int TIMEOUT    = 8,
    parameter int SKIP_WADDR = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic                 cmd_rw,
    input  logic [ADDR_SIZE-1:0] cmd_addr,
    input  logic [ADDR_SIZE-1:0] cmd_wdata,
    output logic                 rsp_valid,
    output logic [ADDR_SIZE-1:0] rsp_data,
    output logic                 rsp_err,
    output logic                 ram_rx_valid,
    output logic [ADDR_SIZE+1:0] ram_din,
    input  logic [ADDR_SIZE-1:0] ram_dout,
    input  logic                 ram_tx_valid,
    output logic                 busy
);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_W_ADDR, S_W_DATA, S_R_ADDR, S_R_CMD, S_R_WAIT, S_RESP
    } state_t;

    state_t                 r_state;
    state_t                 w_nxt;
    logic [ADDR_SIZE-1:0]   r_addr;
    logic [ADDR_SIZE-1:0]   r_wdata;
    logic [ADDR_SIZE-1:0]   r_cache_addr;
    logic                   r_cache_vld;
    logic [CW-1:0]          r_cnt;
    logic                   w_hit;
    logic                   w_timeout;
    logic                   w_rx_valid;
    logic [ADDR_SIZE+1:0]   w_din;

    assign w_hit     = (SKIP_WADDR != 0) && r_cache_vld && (cmd_addr == r_cache_addr);
    assign w_timeout = (r_cnt == CW'(TIMEOUT - 1));

    // Outputs are registered, so the command word is decoded from the state being entered.
    always_comb begin
        w_nxt      = r_state;
        w_rx_valid = 1'b0;
        w_din      = '0;
        unique case (r_state)
            S_IDLE:   if (cmd_valid) w_nxt = cmd_rw ? S_R_ADDR : (w_hit ? S_W_DATA : S_W_ADDR);
            S_W_ADDR: w_nxt = S_W_DATA;
            S_W_DATA: w_nxt = S_IDLE;
            S_R_ADDR: w_nxt = S_R_CMD;
            S_R_CMD:  w_nxt = S_R_WAIT;
            S_R_WAIT: if (ram_tx_valid || w_timeout) w_nxt = S_RESP;
            S_RESP:   w_nxt = S_IDLE;
            default:  w_nxt = S_IDLE;
        endcase
        unique case (w_nxt)
            S_W_ADDR: begin
                w_rx_valid = 1'b1;
                w_din      = {2'b00, cmd_addr};
            end
            S_W_DATA: begin
                w_rx_valid = 1'b1;
                w_din      = {2'b01, (r_state == S_IDLE) ? cmd_wdata : r_wdata};
            end
            S_R_ADDR: begin
                w_rx_valid = 1'b1;
                w_din      = {2'b10, cmd_addr};
            end
            S_R_CMD: begin
                w_rx_valid = 1'b1;
                w_din      = {2'b11, {ADDR_SIZE{1'b0}}};
            end
            default: begin
                w_rx_valid = 1'b0;
                w_din      = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            cmd_ready    <= 1'b1;
            busy         <= 1'b0;
            rsp_valid    <= 1'b0;
            rsp_data     <= '0;
            rsp_err      <= 1'b0;
            ram_rx_valid <= 1'b0;
            ram_din      <= '0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_cache_addr <= '0;
            r_cache_vld  <= 1'b0;
            r_cnt        <= '0;
        end else begin
            r_state      <= w_nxt;
            cmd_ready    <= (w_nxt == S_IDLE);
            busy         <= (w_nxt != S_IDLE);
            rsp_valid    <= (w_nxt == S_RESP);
            ram_rx_valid <= w_rx_valid;
            ram_din      <= w_din;
            if (r_state == S_IDLE && cmd_valid) begin
                r_addr  <= cmd_addr;
                r_wdata <= cmd_wdata;
            end
            if (r_state == S_W_ADDR) begin
                r_cache_vld  <= 1'b1;
                r_cache_addr <= r_addr;
            end
            // Held at zero outside R_WAIT, saturates at TIMEOUT instead of wrapping.
            if (r_state != S_R_WAIT) begin
                r_cnt <= '0;
            end else if (!ram_tx_valid && r_cnt != CW'(TIMEOUT)) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (r_state == S_R_WAIT && w_nxt == S_RESP) begin
                rsp_err  <= !ram_tx_valid;
                rsp_data <= ram_tx_valid ? ram_dout : '0;
            end
        end
    end
endmodule

// File: tb/tb_ram_cmd_master.sv
// Bench for ram_cmd_master: directed scenarios then a random write/read stream, each request checked
// cycle by cycle against a request-level reference model with an attached behavioural RAM.
`timescale 1ns/1ps
module tb_ram_cmd_master;
    localparam int AW = 8;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_rw;
    logic [AW-1:0] cmd_addr;
    logic [AW-1:0] cmd_wdata;
    logic          rsp_valid;
    logic [AW-1:0] rsp_data;
    logic          rsp_err;
    logic          ram_rx_valid;
    logic [AW+1:0] ram_din;
    logic [AW-1:0] ram_dout = '0;
    logic          ram_tx_valid = 1'b0;
    logic          busy;

    int n_chk = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    ram_cmd_master #(.ADDR_SIZE(AW), .TIMEOUT(TO), .SKIP_WADDR(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rw(cmd_rw),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .ram_rx_valid(ram_rx_valid), .ram_din(ram_din),
        .ram_dout(ram_dout), .ram_tx_valid(ram_tx_valid), .busy(busy)
    );

    // Behavioural dual-port RAM; op 11 is decoded without looking at rx_valid, as the real RAM does.
    logic [AW-1:0] mem [256] = '{default: '0};
    logic [AW-1:0] wptr = '0;
    logic [AW-1:0] rptr = '0;
    int            pend = 0;
    bit            ram_on = 1'b1;
    int            ram_lat = 0;

    always @(posedge clk) begin
        ram_tx_valid <= 1'b0;
        if (pend > 0) begin
            pend <= pend - 1;
            if (pend == 1) begin
                ram_tx_valid <= ram_on;
                ram_dout     <= mem[rptr];
            end
        end
        if (ram_din[AW+1:AW] == 2'b11) begin
            if (ram_lat == 0) begin
                ram_tx_valid <= ram_on;
                ram_dout     <= mem[rptr];
            end else begin
                pend <= ram_lat;
            end
        end else if (ram_rx_valid) begin
            case (ram_din[AW+1:AW])
                2'b00:   wptr <= ram_din[AW-1:0];
                2'b01:   mem[wptr] <= ram_din[AW-1:0];
                2'b10:   rptr <= ram_din[AW-1:0];
                default: ;
            endcase
        end
    end

    // Request-level reference state.
    logic [AW-1:0] ref_mem [256] = '{default: '0};
    bit            ref_cv = 1'b0;
    logic [AW-1:0] ref_ca = '0;
    logic [AW-1:0] ref_rd = '0;
    bit            ref_re = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic reset_chk(input string tag);
        chk({tag, "_ready"}, cmd_ready, 1);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_rspv"}, rsp_valid, 0);
        chk({tag, "_rspd"}, rsp_data, 0);
        chk({tag, "_rspe"}, rsp_err, 0);
        chk({tag, "_rxv"}, ram_rx_valid, 0);
        chk({tag, "_din"}, ram_din, 0);
    endtask

    // Called at a negedge where the master should be idle; returns at the next idle negedge.
    task automatic do_req(input bit rw, input logic [AW-1:0] a, input logic [AW-1:0] d, input int lat);
        logic [AW+1:0] exp_q[$];
        int            waited;
        int            exp_wait;
        logic [AW-1:0] exp_data;
        chk("idle_ready", cmd_ready, 1);
        chk("idle_busy", busy, 0);
        chk("idle_rxv", ram_rx_valid, 0);
        chk("idle_din", ram_din, 0);
        chk("idle_rspv", rsp_valid, 0);
        chk("hold_rspd", rsp_data, ref_rd);
        chk("hold_rspe", rsp_err, ref_re);
        cmd_valid = 1'b1;
        cmd_rw    = rw;
        cmd_addr  = a;
        cmd_wdata = d;
        ram_lat   = lat;
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_rw    = 1'($urandom);
        cmd_addr  = AW'($urandom);
        cmd_wdata = AW'($urandom);
        if (!rw) begin
            if (!(ref_cv && ref_ca == a)) exp_q.push_back({2'b00, a});
            exp_q.push_back({2'b01, d});
            ref_cv   = 1'b1;
            ref_ca   = a;
            ref_mem[a] = d;
        end else begin
            exp_q.push_back({2'b10, a});
            exp_q.push_back({2'b11, {AW{1'b0}}});
        end
        foreach (exp_q[i]) begin
            chk("ph_rxv", ram_rx_valid, 1);
            chk("ph_din", ram_din, exp_q[i]);
            chk("ph_ready", cmd_ready, 0);
            chk("ph_busy", busy, 1);
            chk("ph_rspv", rsp_valid, 0);
            @(negedge clk);
        end
        if (rw) begin
            exp_wait = ram_on ? 1 + lat : TO;
            exp_data = ram_on ? ref_mem[a] : '0;
            waited   = 0;
            while (!rsp_valid && waited < TO + 6) begin
                chk("wait_din", ram_din, 0);
                chk("wait_rxv", ram_rx_valid, 0);
                chk("wait_busy", busy, 1);
                @(negedge clk);
                waited++;
            end
            chk("rd_latency", waited, exp_wait);
            chk("rd_rspv", rsp_valid, 1);
            chk("rd_data", rsp_data, exp_data);
            chk("rd_err", rsp_err, !ram_on);
            chk("rd_ready", cmd_ready, 0);
            chk("rd_din", ram_din, 0);
            ref_rd = exp_data;
            ref_re = !ram_on;
            @(negedge clk);
            chk("rd_pulse", rsp_valid, 0);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_rw    = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        repeat (2) @(negedge clk);
        reset_chk("rst");
        rst_n = 1'b1;
        @(negedge clk);

        do_req(1'b0, 8'h3C, 8'hA5, 0);
        do_req(1'b0, 8'h3C, 8'h5A, 0);
        do_req(1'b0, 8'h3D, 8'h5D, 0);
        do_req(1'b1, 8'h3C, 8'h00, 0);
        ram_on = 1'b0;
        do_req(1'b1, 8'h3D, 8'h00, 0);
        ram_on = 1'b1;
        do_req(1'b1, 8'h3D, 8'h00, 2);

        // Abort a write in its data phase; the cache must forget 0x70.
        cmd_valid = 1'b1;
        cmd_rw    = 1'b0;
        cmd_addr  = 8'h70;
        cmd_wdata = 8'h11;
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("ab_waddr", ram_din, {2'b00, 8'h70});
        @(negedge clk);
        chk("ab_wdata", ram_din, {2'b01, 8'h11});
        rst_n = 1'b0;
        #1;
        reset_chk("ab_rst");
        ref_cv = 1'b0;
        ref_rd = '0;
        ref_re = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        do_req(1'b0, 8'h70, 8'h22, 0);
        do_req(1'b1, 8'h70, 8'h00, 1);

        for (int i = 0; i < 80; i++) begin
            do_req(1'($urandom_range(0, 1)), AW'(8'h38 + $urandom_range(0, 7)),
                   AW'($urandom), $urandom_range(0, 3));
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
